// File: rtl/ysyx_23060332_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU physical-memory arbiter.
package ysyx_23060332_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [31:0] PMEM_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] PMEM_END_DEF  = 32'h87ff_ffff;
  localparam int          CNT_W         = 4;

  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] last);
    return (addr < base) || (addr > last);
  endfunction

endpackage

// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// Requester handshakes plus the memory pins; slave = arbiter side, master = requesters and memory.
interface ysyx_23060332_mem_arbiter_if;

  logic        ifu_valid;
  logic        ifu_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] ifu_rdata;
  logic        ifu_err;

  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rvalid;
  logic        lsu_rready;
  logic [31:0] lsu_rdata;
  logic        lsu_err;

  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;

  modport slave (
    input  ifu_valid, ifu_addr, ifu_rready,
    output ifu_ready, ifu_rvalid, ifu_rdata, ifu_err,
    input  lsu_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask, lsu_rready,
    output lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
    input  mem_rdata
  );

  modport master (
    output ifu_valid, ifu_addr, ifu_rready,
    input  ifu_ready, ifu_rvalid, ifu_rdata, ifu_err,
    output lsu_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask, lsu_rready,
    input  lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
    output mem_rdata
  );

endinterface

// File: rtl/ysyx_23060332_rr_arb2.sv
// Two-input round-robin grant; on a tie the side that did not win last time is chosen.
module ysyx_23060332_rr_arb2
  import ysyx_23060332_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic upd,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  owner_e last_q;

  always_comb begin
    gnt_ifu = req_ifu && (!req_lsu || (last_q == OWN_LSU));
    gnt_lsu = req_lsu && !gnt_ifu;
  end

  // Starts at LSU so the IFU wins the first tie out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_LSU;
    end else if (upd && (gnt_ifu || gnt_lsu)) begin
      last_q <= gnt_lsu ? OWN_LSU : OWN_IFU;
    end
  end

endmodule

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Round-robin IFU/LSU arbiter for the single PMEM port with programmable access latency
// and out-of-window fault responses that never strobe memory.
module ysyx_23060332_mem_arbiter
  import ysyx_23060332_mem_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] PMEM_BASE = PMEM_BASE_DEF,
  parameter logic [31:0] PMEM_END  = PMEM_END_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_23060332_mem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q;
  logic             we_q, err_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [7:0]       wmask_q;
  logic [CNT_W-1:0] cnt_q;

  logic        gnt_ifu, gnt_lsu;
  logic        hs, strobe, rd_hit, wr_hit, resp_done, ifu_resp, lsu_resp;
  logic [31:0] req_addr;

  ysyx_23060332_rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_ifu (bus.ifu_valid),
    .req_lsu (bus.lsu_valid),
    .upd     (hs),
    .gnt_ifu (gnt_ifu),
    .gnt_lsu (gnt_lsu)
  );

  assign hs        = (state_q == IDLE) && (gnt_ifu || gnt_lsu);
  assign strobe    = (state_q == BUSY) && (cnt_q == '0);
  assign rd_hit    = strobe && !we_q && !err_q;
  assign wr_hit    = strobe && we_q && !err_q;
  assign ifu_resp  = (state_q == RESP) && (owner_q == OWN_IFU);
  assign lsu_resp  = (state_q == RESP) && (owner_q == OWN_LSU);
  assign resp_done = (ifu_resp && bus.ifu_rready) || (lsu_resp && bus.lsu_rready);
  assign req_addr  = gnt_lsu ? bus.lsu_addr : bus.ifu_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.ifu_ready  = (state_q == IDLE) && gnt_ifu;
    bus.lsu_ready  = (state_q == IDLE) && gnt_lsu;
    bus.ifu_rvalid = ifu_resp;
    bus.ifu_rdata  = ifu_resp ? rdata_q : '0;
    bus.ifu_err    = ifu_resp && err_q;
    bus.lsu_rvalid = lsu_resp;
    bus.lsu_rdata  = lsu_resp ? rdata_q : '0;
    bus.lsu_err    = lsu_resp && err_q;
    bus.mem_ren    = rd_hit;
    bus.mem_raddr  = rd_hit ? addr_q : '0;
    bus.mem_wen    = wr_hit;
    bus.mem_waddr  = wr_hit ? addr_q : '0;
    bus.mem_wdata  = wr_hit ? wdata_q : '0;
    bus.mem_wmask  = wr_hit ? wmask_q : '0;
    unique case (state_q)
      IDLE:    if (hs)        state_d = BUSY;
      BUSY:    if (strobe)    state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Holding registers load only on the IDLE handshake; the response word is captured at the strobe edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_IFU;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (hs) begin
        owner_q <= gnt_lsu ? OWN_LSU : OWN_IFU;
        we_q    <= gnt_lsu && bus.lsu_we;
        addr_q  <= req_addr;
        wdata_q <= gnt_lsu ? bus.lsu_wdata : '0;
        wmask_q <= gnt_lsu ? bus.lsu_wmask : '0;
        err_q   <= addr_fault(req_addr, PMEM_BASE, PMEM_END);
        cnt_q   <= CNT_LOAD;
      end else if ((state_q == BUSY) && !strobe) begin
        cnt_q   <= cnt_q - 1'b1;
      end
      if (strobe) begin
        rdata_q <= rd_hit ? bus.mem_rdata : '0;
      end
    end
  end

endmodule
